// File: rtl/shared_unit_arbiter_if.sv
// Handshake bundle between the two pipelines, the arbiter and the shared resource.
// The slave side is the arbiter; the master side drives requests and the resource responses.
interface shared_unit_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              req_1;
  logic              req_2;
  logic [DATA_W-1:0] op_1;
  logic [DATA_W-1:0] op_2;
  logic              flush_1;
  logic              flush_2;
  logic              stall_1;
  logic              stall_2;
  logic              rs_valid;
  logic [DATA_W-1:0] rs_data;
  logic              rs_ready;
  logic              rs_done;
  logic [DATA_W-1:0] rs_result;
  logic              res_valid_1;
  logic              res_valid_2;
  logic [DATA_W-1:0] res_data;
  logic              err_timeout;

  modport slave (
    input  req_1, req_2, op_1, op_2, flush_1, flush_2,
    input  rs_ready, rs_done, rs_result,
    output stall_1, stall_2, rs_valid, rs_data,
    output res_valid_1, res_valid_2, res_data, err_timeout
  );

  modport master (
    output req_1, req_2, op_1, op_2, flush_1, flush_2,
    output rs_ready, rs_done, rs_result,
    input  stall_1, stall_2, rs_valid, rs_data,
    input  res_valid_1, res_valid_2, res_data, err_timeout
  );
endinterface

// File: rtl/shared_unit_arbiter.sv
// Round-robin arbiter for one shared execution unit serving two pipelines,
// with per-pipeline flush (kill of the in-flight op) and a completion timeout.
module shared_unit_arbiter #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  shared_unit_arbiter_if.slave  bus
);
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic              prio_q, prio_d;
  logic              owner_q, owner_d;
  logic              kill_q, kill_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] operand_q, operand_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              err_q, err_d;

  logic [1:0] req_v, flush_v, elig, res_valid_v, stall_v;
  logic       winner;
  logic       kill_now;

  assign req_v   = {bus.req_2, bus.req_1};
  assign flush_v = {bus.flush_2, bus.flush_1};

  // Index 0 is pipeline 1, index 1 is pipeline 2 throughout.
  for (genvar gi = 0; gi < 2; gi++) begin : g_pipe
    assign elig[gi]    = req_v[gi] & ~flush_v[gi];
    assign stall_v[gi] = elig[gi] & ~res_valid_v[gi];
  end

  assign bus.stall_1 = stall_v[0];
  assign bus.stall_2 = stall_v[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      prio_q    <= 1'b0;
      owner_q   <= 1'b0;
      kill_q    <= 1'b0;
      cnt_q     <= '0;
      operand_q <= '0;
      result_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      owner_q   <= owner_d;
      kill_q    <= kill_d;
      cnt_q     <= cnt_d;
      operand_q <= operand_d;
      result_q  <= result_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    owner_d   = owner_q;
    kill_d    = kill_q;
    cnt_d     = cnt_q;
    operand_d = operand_q;
    result_d  = result_q;
    err_d     = err_q;
    winner    = 1'b0;
    kill_now  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (|elig) begin
          winner    = (elig == 2'b11) ? prio_q : elig[1];
          owner_d   = winner;
          operand_d = winner ? bus.op_2 : bus.op_1;
          prio_d    = ~winner;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (flush_v[owner_q]) kill_d = 1'b1;
        if (bus.rs_ready) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        // A flush landing in the same cycle as rs_done still suppresses the response.
        kill_now = kill_q | flush_v[owner_q];
        kill_d   = kill_now;
        cnt_d    = cnt_q + CNT_W'(1);
        if (bus.rs_done) begin
          if (kill_now) begin
            state_d = S_IDLE;
            kill_d  = 1'b0;
          end else begin
            result_d = bus.rs_result;
            state_d  = S_RESP;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
          kill_d  = 1'b0;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.rs_valid    = (state_q == S_ISSUE);
    bus.rs_data     = (state_q == S_ISSUE) ? operand_q : '0;
    res_valid_v     = 2'b00;
    if (state_q == S_RESP) res_valid_v = owner_q ? 2'b10 : 2'b01;
    bus.res_valid_1 = res_valid_v[0];
    bus.res_valid_2 = res_valid_v[1];
    bus.res_data    = result_q;
    bus.err_timeout = err_q;
  end
endmodule

// File: tb/tb_shared_unit_arbiter.sv
// Randomized bench for shared_unit_arbiter against a transaction-level reference model.
module tb_shared_unit_arbiter;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  shared_unit_arbiter_if #(.DATA_W(DATA_W)) bus ();

  shared_unit_arbiter #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: an operation is either absent, offered, in flight or being delivered.
  bit          m_busy, m_acc, m_doomed, m_deliver, m_err;
  int          m_who, m_fav, m_age;
  logic [31:0] m_opnd, m_res;

  bit          exp_rv1, exp_rv2;
  logic        r1, r2, f1, f2, prev_rv1, prev_rv2, prev_f1, prev_f2;
  logic [31:0] o1, o2;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_acc = 0; m_doomed = 0; m_deliver = 0; m_err = 0;
    m_who = 1; m_fav = 1; m_age = 0; m_opnd = '0; m_res = '0;
  endtask

  task automatic step(input logic rst, input logic rq1, rq2, input logic [31:0] a1, a2,
                      input logic fl1, fl2, rdy, dn, input logic [31:0] rres);
    bit          e1, e2, exp_rsv, owner_flush;
    logic [31:0] exp_rsd;
    reset         = rst;
    bus.req_1     = rq1;   bus.req_2     = rq2;
    bus.op_1      = a1;    bus.op_2      = a2;
    bus.flush_1   = fl1;   bus.flush_2   = fl2;
    bus.rs_ready  = rdy;   bus.rs_done   = dn;
    bus.rs_result = rres;
    @(negedge clk);
    exp_rsv = m_busy && !m_acc && !m_deliver;
    exp_rsd = exp_rsv ? m_opnd : 32'h0;
    exp_rv1 = m_deliver && (m_who == 1);
    exp_rv2 = m_deliver && (m_who == 2);
    check_val("rs_valid",    bus.rs_valid,    exp_rsv);
    check_val("rs_data",     bus.rs_data,     exp_rsd);
    check_val("res_valid_1", bus.res_valid_1, exp_rv1);
    check_val("res_valid_2", bus.res_valid_2, exp_rv2);
    check_val("res_data",    bus.res_data,    m_res);
    check_val("err_timeout", bus.err_timeout, m_err);
    check_val("stall_1",     bus.stall_1,     rq1 && !fl1 && !exp_rv1);
    check_val("stall_2",     bus.stall_2,     rq2 && !fl2 && !exp_rv2);
    if (exp_rv1 || exp_rv2)
      $display("txn t=%0t pipe=%0d data=%08h", $time, m_who, m_res);
    // Advance the model by one clock edge.
    e1 = rq1 && !fl1;
    e2 = rq2 && !fl2;
    owner_flush = (m_who == 1) ? fl1 : fl2;
    if (rst) begin
      model_reset();
    end else if (m_deliver) begin
      m_deliver = 0; m_busy = 0;
    end else if (!m_busy) begin
      if (e1 || e2) begin
        m_who    = (e1 && e2) ? m_fav : (e1 ? 1 : 2);
        m_opnd   = (m_who == 1) ? a1 : a2;
        m_fav    = 3 - m_who;
        m_busy   = 1; m_acc = 0; m_doomed = 0;
      end
    end else if (!m_acc) begin
      if (owner_flush) m_doomed = 1;
      if (rdy) begin m_acc = 1; m_age = 0; end
    end else begin
      if (owner_flush) m_doomed = 1;
      if (dn) begin
        if (m_doomed) begin m_busy = 0; m_doomed = 0; end
        else begin m_res = rres; m_deliver = 1; end
      end else if (m_age == TIMEOUT - 1) begin
        m_err = 1; m_busy = 0; m_doomed = 0;
      end else begin
        m_age++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 1, 1, $urandom);
  endtask

  task automatic rand_cycle(input int p_req, p_flush, p_rdy, p_done, p_rst);
    if (prev_rv1 || prev_f1) begin
      r1 = ($urandom_range(0, 99) < p_req); o1 = $urandom;
    end else if (!r1 && $urandom_range(0, 99) < p_req) begin
      r1 = 1; o1 = $urandom;
    end
    if (prev_rv2 || prev_f2) begin
      r2 = ($urandom_range(0, 99) < p_req); o2 = $urandom;
    end else if (!r2 && $urandom_range(0, 99) < p_req) begin
      r2 = 1; o2 = $urandom;
    end
    f1 = r1 && ($urandom_range(0, 99) < p_flush);
    f2 = r2 && ($urandom_range(0, 99) < p_flush);
    step(($urandom_range(0, 999) < p_rst), r1, r2, o1, o2, f1, f2,
         ($urandom_range(0, 99) < p_rdy), ($urandom_range(0, 99) < p_done), $urandom);
    prev_rv1 = exp_rv1; prev_rv2 = exp_rv2; prev_f1 = f1; prev_f2 = f2;
  endtask

  initial begin
    r1 = 0; r2 = 0; f1 = 0; f2 = 0; o1 = '0; o2 = '0;
    prev_rv1 = 0; prev_rv2 = 0; prev_f1 = 0; prev_f2 = 0;
    reset = 1;
    bus.req_1 = 0; bus.req_2 = 0; bus.op_1 = '0; bus.op_2 = '0;
    bus.flush_1 = 0; bus.flush_2 = 0; bus.rs_ready = 0; bus.rs_done = 0; bus.rs_result = '0;
    model_reset();
    @(posedge clk);
    #1;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Minimum-latency single operation from pipeline 1.
    step(0, 1, 0, 32'h5, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 32'h5, 0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 32'h5, 0, 0, 0, 0, 1, 32'hA);
    step(0, 1, 0, 32'h5, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Both pipelines requesting continuously: grants alternate.
    for (int i = 0; i < 20; i++) rand_cycle(100, 0, 100, 100, 0);
    r1 = 0; r2 = 0; idle_cycles(6);

    // Resource stalls rs_ready for 5 cycles in ISSUE.
    step(0, 0, 1, 0, 32'hBEEF, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 32'hBEEF, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 32'hBEEF, 0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 32'hBEEF, 0, 0, 0, 1, 32'h1234);
    step(0, 0, 1, 0, 32'hBEEF, 0, 0, 0, 0, 0);
    idle_cycles(6);

    // Owner (pipeline 2) flushed in WAIT; late rs_done gives no response; pipeline 1 next.
    step(0, 0, 1, 32'h11, 32'h22, 0, 0, 0, 0, 0);
    step(0, 0, 1, 32'h11, 32'h22, 0, 0, 1, 0, 0);
    step(0, 1, 1, 32'h11, 32'h22, 0, 1, 0, 0, 0);
    step(0, 1, 0, 32'h11, 32'h22, 0, 0, 0, 1, 32'h99);
    step(0, 1, 0, 32'h11, 32'h22, 0, 0, 0, 0, 0);
    step(0, 1, 0, 32'h11, 32'h22, 0, 0, 1, 0, 0);
    step(0, 1, 0, 32'h11, 32'h22, 0, 0, 0, 1, 32'h77);
    step(0, 1, 0, 32'h11, 32'h22, 0, 0, 0, 0, 0);
    idle_cycles(6);

    // Hung resource: timeout, sticky error, then re-issue of the same request.
    step(0, 1, 0, 32'h33, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 32'h33, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < TIMEOUT + 3; i++) step(0, 1, 0, 32'h33, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 32'h33, 0, 0, 0, 1, 0, 0);
    step(0, 1, 0, 32'h33, 0, 0, 0, 0, 1, 32'h44);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle_cycles(6);

    // Reset in WAIT; rs_done two cycles after release is ignored.
    step(0, 0, 1, 0, 32'h55, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 32'h55, 0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 32'h55, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h66);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Random traffic in several regimes.
    for (int i = 0; i < 1500; i++) rand_cycle(60, 5, 60, 40, 2);
    for (int i = 0; i < 500; i++)  rand_cycle(90, 0, 80, 3, 1);
    for (int i = 0; i < 1000; i++) rand_cycle(80, 20, 50, 50, 5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/shared_unit_arbiter.md
Name: shared_unit_arbiter

Overview:
- Controls the single shared execution resource used by the two pipelines.
- Arbitrates round-robin between pipeline 1 and pipeline 2, issues one operation at a time to the resource over a valid/ready handshake, and waits for completion.
- Routes the result back to the requester that owns the operation and generates the global stall signals stall_1/stall_2.
- Handles per-pipeline flush and guards against a hung resource with a timeout.

Parameters:
DATA_W, 32, operand/result width
TIMEOUT, 16, max cycles in WAIT without rs_done before abort (>=2)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
req_1  input  1  pipeline 1 requests shared unit; held until result delivered or flushed
req_2  input  1  pipeline 2 request, same rules
op_1  input  DATA_W  pipeline 1 operand, valid with req_1
op_2  input  DATA_W  pipeline 2 operand
flush_1  input  1  kill pipeline 1's request / in-flight op
flush_2  input  1  kill pipeline 2's request / in-flight op
stall_1  output  1  stall pipeline 1
stall_2  output  1  stall pipeline 2
rs_valid  output  1  operation offered to resource
rs_data  output  DATA_W  operand to resource
rs_ready  input  1  resource accepts operation
rs_done  input  1  one-cycle completion pulse from resource
rs_result  input  DATA_W  result, valid with rs_done
res_valid_1  output  1  result for pipeline 1 (one-cycle pulse)
res_valid_2  output  1  result for pipeline 2 (one-cycle pulse)
res_data  output  DATA_W  result data, valid with either res_valid
err_timeout  output  1  sticky timeout flag

Behaviour:
- Reset (synchronous, active-high): state=IDLE, prio=0 (pipeline 1 favoured), owner=0, kill=0, wait counter=0, operand reg=0, result reg=0, err_timeout=0. All outputs 0 except stall_i, which is combinational.
- A reset asserted mid-operation abandons the operation. Any rs_done arriving later is ignored in IDLE.
- States:
  - IDLE: eligible_i = req_i & ~flush_i.
    - One eligible: grant it.
    - Both eligible: grant the requester selected by prio.
    - On a grant: owner<=winner, operand reg<=op_winner, prio<=other requester, go to ISSUE.
    - None eligible: stay in IDLE.
  - ISSUE: rs_valid=1, rs_data=operand reg. rs_valid stays high until rs_ready, even if the owner is flushed. When rs_valid & rs_ready: go to WAIT, clear counter.
  - WAIT: counter increments each cycle.
    - On rs_done with kill=0: result reg<=rs_result, go to RESP.
    - On rs_done with kill=1: go to IDLE, clear kill, no response.
    - If the counter reaches TIMEOUT-1 without rs_done: err_timeout<=1, go to IDLE, clear kill. The owner's request is then re-arbitrated normally.
  - RESP: res_valid_owner=1 for exactly one cycle, res_data=result reg, then go to IDLE. The next arbitration happens in the IDLE cycle after RESP.
- rs_done outside WAIT is ignored. rs_ready outside ISSUE is ignored.
- Kill:
  - flush_owner in ISSUE or WAIT sets kill.
  - flush of the non-owner has no effect on the in-flight op.
  - Flush does not change prio.
- Stall: stall_i = req_i & ~flush_i & ~res_valid_i (combinational). The requester drops or replaces req_i in the cycle after res_valid_i.
- Minimum latency, with rs_ready and rs_done both returned at the earliest opportunity:
  - req seen in IDLE at cycle 0
  - ISSUE at cycle 1
  - WAIT at cycle 2
  - RESP (res_valid) at cycle 3
- Fairness: under continuous requests from both pipelines, grants strictly alternate.
- res_data holds its last value when no res_valid is high.

Test Plan:
- Reset, then req_1=1 with op_1=0x0000_0005; resource drives rs_ready=1 at cycle 1 and rs_done=1 with rs_result=0x0000_000A at cycle 2 -> rs_valid=1 with rs_data=5 at cycle 1; res_valid_1=1 with res_data=0xA at cycle 3; stall_1=1 on cycles 0-2 and 0 on cycle 3; stall_2=0 throughout.
- req_1 and req_2 held together for 4 operations -> grant order 1,2,1,2. The non-owner's stall stays high until its own RESP; no two res_valid pulses occur in the same cycle.
- rs_ready held low for 5 cycles in ISSUE -> rs_valid and rs_data stay stable all 5 cycles; WAIT is entered the cycle after rs_ready rises.
- Owner (pipeline 2) flushed during WAIT; rs_done follows -> no res_valid_2; state returns to IDLE; a pending req_1 is granted next; prio is unchanged by the flush.
- rs_done never arrives, TIMEOUT=16 -> err_timeout=1 after 16 WAIT cycles, state returns to IDLE, the request is re-issued, and err_timeout stays 1 until reset.
- Reset asserted during WAIT, with rs_done arriving 2 cycles after reset release -> all outputs are 0, the late rs_done is ignored, and no res_valid pulse occurs.
